// File: rtl/sdram_pkg.sv
// Shared encodings, FSM state type and byte helpers for the SDRAM host client.
package sdram_pkg;

  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b11;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    WAIT
  } state_e;

  // Even byte address maps to the high byte of the word (big-endian).
  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic lo);
    return lo ? word[7:0] : word[15:8];
  endfunction

  function automatic logic [1:0] byte_ds(input logic lo);
    return lo ? DS_LO : DS_HI;
  endfunction

endpackage

// File: rtl/sdram_rdbuf.sv
// One-word read buffer: tag/valid/data, hit compare, byte select and posted-write merge.
module sdram_rdbuf
  import sdram_pkg::*;
#(
  parameter int unsigned BUF_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fill,
  input  logic [20:0] i_fill_tag,
  input  logic [15:0] i_fill_data,
  input  logic        i_wr,
  input  logic [21:0] i_wr_a,
  input  logic [7:0]  i_wr_d,
  input  logic [21:0] i_rd_a,
  output logic        o_hit,
  output logic [7:0]  o_byte
);

  logic        r_valid;
  logic [20:0] r_tag;
  logic [15:0] r_data;
  logic        w_wr_match;

  assign w_wr_match = r_valid && (r_tag == i_wr_a[21:1]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end else if (i_wr && w_wr_match) begin
      // Keep the buffered copy coherent with the posted write.
      if (i_wr_a[0]) r_data[7:0]  <= i_wr_d;
      else           r_data[15:8] <= i_wr_d;
    end
  end

  assign o_hit  = (BUF_EN != 0) && r_valid && (r_tag == i_rd_a[21:1]);
  assign o_byte = sel_byte(r_data, i_rd_a[0]);

endmodule

// File: rtl/sdram_client.sv
// Host-side initiator for the SDRAM controller toggle req/ack port: byte strobes to word
// transactions, one-word read buffer, posted writes and an ack timeout watchdog.
module sdram_client
  import sdram_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned BUF_EN  = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_host_rd,
  input  logic        i_host_wr,
  input  logic [21:0] i_host_a,
  input  logic [7:0]  i_host_din,
  output logic [7:0]  o_host_dout,
  output logic        o_host_valid,
  output logic        o_host_busy,
  output logic        o_err,
  output logic        o_port_req,
  input  logic        i_port_ack,
  output logic        o_port_we,
  output logic [20:0] o_port_a,
  output logic [1:0]  o_port_ds,
  output logic [15:0] o_port_d,
  input  logic [15:0] i_port_q
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_e        r_state;
  logic          r_req;
  logic          r_we;
  logic [20:0]   r_a;
  logic [1:0]    r_ds;
  logic [15:0]   r_d;
  logic          r_lo;
  logic [7:0]    r_dout;
  logic          r_valid;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_done;
  logic          w_hit;
  logic [7:0]    w_buf_byte;
  logic          w_fill;
  logic          w_buf_wr;
  logic [CW-1:0] w_cnt_inc;

  assign w_done    = (i_port_ack == r_req);
  assign w_fill    = (r_state == WAIT) && w_done && !r_we;
  assign w_buf_wr  = (r_state == IDLE) && i_host_wr;
  assign w_cnt_inc = r_cnt + 1'b1;

  sdram_rdbuf #(
    .BUF_EN(BUF_EN)
  ) u_rdbuf (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_fill     (w_fill),
    .i_fill_tag (r_a),
    .i_fill_data(i_port_q),
    .i_wr       (w_buf_wr),
    .i_wr_a     (i_host_a),
    .i_wr_d     (i_host_din),
    .i_rd_a     (i_host_a),
    .o_hit      (w_hit),
    .o_byte     (w_buf_byte)
  );

  // r_req is deliberately left out of reset so an in-flight toggle survives it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= SYNC;
      r_we    <= 1'b0;
      r_a     <= '0;
      r_ds    <= '0;
      r_d     <= '0;
      r_lo    <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        SYNC: begin
          if (w_done) r_state <= IDLE;
        end
        IDLE: begin
          if (i_host_wr) begin
            r_we    <= 1'b1;
            r_a     <= i_host_a[21:1];
            r_ds    <= byte_ds(i_host_a[0]);
            r_d     <= {i_host_din, i_host_din};
            r_lo    <= i_host_a[0];
            r_cnt   <= '0;
            r_req   <= ~r_req;
            r_state <= WAIT;
          end else if (i_host_rd) begin
            if (w_hit) begin
              r_dout  <= w_buf_byte;
              r_valid <= 1'b1;
            end else begin
              r_we    <= 1'b0;
              r_a     <= i_host_a[21:1];
              r_ds    <= DS_WORD;
              r_d     <= {i_host_din, i_host_din};
              r_lo    <= i_host_a[0];
              r_cnt   <= '0;
              r_req   <= ~r_req;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (w_done) begin
            if (!r_we) begin
              r_dout  <= sel_byte(i_port_q, r_lo);
              r_valid <= 1'b1;
            end
            r_state <= IDLE;
          end else if ((TIMEOUT != 0) && (r_cnt != CNT_MAX)) begin
            // Counter saturates at TIMEOUT; a late ack still completes the access.
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) r_err <= 1'b1;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  assign o_host_busy  = (r_state != IDLE);
  assign o_host_dout  = r_dout;
  assign o_host_valid = r_valid;
  assign o_err        = r_err;
  assign o_port_req   = r_req;
  assign o_port_we    = r_we;
  assign o_port_a     = r_a;
  assign o_port_ds    = r_ds;
  assign o_port_d     = r_d;

endmodule
